// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-latency load-use hazard unit.
package hazard_pkg;

  // Width of the slot rd field; the top's REG_ADDR_W must not exceed this.
  localparam int unsigned REG_ADDR_W_DFLT = 5;

  localparam logic [REG_ADDR_W_DFLT-1:0] ZERO_REG = '0;

  // One in-flight load: its destination and whether it still blocks readers.
  typedef struct packed {
    logic                       valid;
    logic [REG_ADDR_W_DFLT-1:0] rd;
  } load_slot_t;

endpackage

// File: rtl/hazard_unit_mlat_if.sv
// Pipeline-side control bundle of the hazard unit. The pipeline is the master,
// the hazard unit the slave; signal suffixes are from the hazard unit's view.
interface hazard_unit_mlat_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  idex_memread_i;
  logic [REG_ADDR_W-1:0] idex_rd_i;
  logic [REG_ADDR_W-1:0] ifid_rs1_i;
  logic [REG_ADDR_W-1:0] ifid_rs2_i;
  logic                  ifid_use_rs1_i;
  logic                  ifid_use_rs2_i;
  logic                  branch_taken_i;
  logic                  dmem_busy_i;
  logic                  clr_cnt_i;
  logic                  noop_o;
  logic                  pcwrite_o;
  logic                  stall_o;
  logic                  flush_o;
  logic                  freeze_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  modport master (
    output idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i, ifid_use_rs1_i,
           ifid_use_rs2_i, branch_taken_i, dmem_busy_i, clr_cnt_i,
    input  noop_o, pcwrite_o, stall_o, flush_o, freeze_o, stall_cnt_o
  );

  modport slave (
    input  idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i, ifid_use_rs1_i,
           ifid_use_rs2_i, branch_taken_i, dmem_busy_i, clr_cnt_i,
    output noop_o, pcwrite_o, stall_o, flush_o, freeze_o, stall_cnt_o
  );
endinterface

// File: rtl/load_track_pipe.sv
// Shift register of in-flight loads. Slot 0 is the live ID/EX load; slots
// 1..Depth-1 are the same load aged by one cycle per un-held clock.
module load_track_pipe
  import hazard_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       hold_i,
  input  load_slot_t slot_i,
  output load_slot_t slots_o [Depth]
);

  assign slots_o[0] = slot_i;

  if (Depth > 1) begin : g_regs
    load_slot_t regs_d [Depth-1];
    load_slot_t regs_q [Depth-1];

    // Next state: advance one slot per cycle unless the pipe is held.
    always_comb begin
      regs_d = regs_q;
      if (!hold_i) begin
        regs_d[0] = slot_i;
        for (int k = 1; k < Depth - 1; k++) begin
          regs_d[k] = regs_q[k-1];
        end
      end
    end

    // Slot registers with synchronous clear.
    always_ff @(posedge clk_i) begin
      if (clr_i) begin
        for (int k = 0; k < Depth - 1; k++) begin
          regs_q[k] <= '0;
        end
      end else begin
        regs_q <= regs_d;
      end
    end

    for (genvar k = 0; k < Depth - 1; k++) begin : g_out
      assign slots_o[k+1] = regs_q[k];
    end
  end else begin : g_none
    // Single-cycle latency: nothing to remember.
    logic unused;
    assign unused = ^{clk_i, clr_i, hold_i};
  end

endmodule

// File: rtl/hazard_unit_mlat.sv
// Load-use hazard unit for a data memory with LOAD_LAT cycles of load latency.
// Also drives branch flush, whole-pipe freeze on a busy memory and a
// saturating count of load-use stall cycles.
module hazard_unit_mlat
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DFLT,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  hazard_unit_mlat_if.slave bus
);

  load_slot_t       slot_live;
  load_slot_t       slots [LOAD_LAT];
  logic             hazard;
  logic             freeze;
  logic             stall_inc;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [REG_ADDR_W_DFLT-1:0] rs1, rs2;

  assign rs1            = REG_ADDR_W_DFLT'(bus.ifid_rs1_i);
  assign rs2            = REG_ADDR_W_DFLT'(bus.ifid_rs2_i);
  assign slot_live.rd    = REG_ADDR_W_DFLT'(bus.idex_rd_i);
  assign slot_live.valid = bus.idex_memread_i && (slot_live.rd != ZERO_REG);

  load_track_pipe #(
    .Depth (LOAD_LAT)
  ) u_track (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .hold_i  (freeze),
    .slot_i  (slot_live),
    .slots_o (slots)
  );

  // Hazard when any still-unforwardable load writes a register ID really reads.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (slots[k].valid && (slots[k].rd != ZERO_REG) &&
          ((bus.ifid_use_rs1_i && (slots[k].rd == rs1)) ||
           (bus.ifid_use_rs2_i && (slots[k].rd == rs2)))) begin
        hazard = 1'b1;
      end
    end
  end

  // Prioritised pipeline controls: busy memory, then branch, then hazard.
  always_comb begin
    bus.noop_o    = 1'b0;
    bus.stall_o   = 1'b0;
    bus.flush_o   = 1'b0;
    bus.pcwrite_o = 1'b1;
    freeze        = 1'b0;
    stall_inc     = 1'b0;
    if (!rst_i) begin
      if (bus.dmem_busy_i) begin
        // Branch flush waits: the frozen pipe keeps branch_taken_i asserted.
        freeze        = 1'b1;
        bus.stall_o   = 1'b1;
        bus.pcwrite_o = 1'b0;
      end else if (bus.branch_taken_i) begin
        // The ID instruction is squashed, so its hazard is irrelevant.
        bus.flush_o = 1'b1;
      end else if (hazard) begin
        bus.noop_o    = 1'b1;
        bus.stall_o   = 1'b1;
        bus.pcwrite_o = 1'b0;
        stall_inc     = 1'b1;
      end
    end
  end

  assign bus.freeze_o = freeze;

  // Counter next state: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_cnt_i) begin
      cnt_d = '0;
    end else if (stall_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: doc/hazard_unit_mlat.md
Name: hazard_unit_mlat

Overview:
- Parametrised successor of the single-cycle load-use detector: tracks loads through a data memory with configurable latency (LOAD_LAT cycles from EX to forwardable result).
- Stalls dependent instructions in ID until every in-flight load target has become forwardable.
- Adds source-use qualification, a branch flush output, a full-pipeline freeze for a busy data memory, and a saturating stall-cycle counter.
- Sits between the ID and EX stages of the 5-stage RISC-V core and drives the PC, IF/ID and ID/EX register controls.

Parameters:
- REG_ADDR_W, 5, register address width.
- LOAD_LAT, 1, cycles a load spends in EX/MEM before its result is forwardable; legal range 1..4. A value of 1 reproduces the classic one-bubble behaviour.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous reset, active-high
- idex_memread_i  input  1  instruction in ID/EX is a load
- idex_rd_i  input  REG_ADDR_W  destination of the ID/EX instruction
- ifid_rs1_i  input  REG_ADDR_W  rs1 of the IF/ID instruction
- ifid_rs2_i  input  REG_ADDR_W  rs2 of the IF/ID instruction
- ifid_use_rs1_i  input  1  IF/ID instruction actually reads rs1
- ifid_use_rs2_i  input  1  IF/ID instruction actually reads rs2
- branch_taken_i  input  1  branch/jump resolved taken in EX
- dmem_busy_i  input  1  data memory not ready; whole pipe must hold
- clr_cnt_i  input  1  clear the stall counter
- noop_o  output  1  insert bubble into ID/EX
- pcwrite_o  output  1  PC update enable
- stall_o  output  1  hold IF/ID
- flush_o  output  1  squash IF/ID
- freeze_o  output  1  hold every pipeline register
- stall_cnt_o  output  CNT_W  load-use stall cycles since reset/clear

Behaviour:
- Pending-load tracker: slot 0 is combinational, valid = idex_memread_i & (idex_rd_i != 0), rd = idex_rd_i. Slots 1..LOAD_LAT-1 are registered.
- Tracker update: each clock with freeze_o=0, slot k+1 <= slot k; the oldest slot retires. With freeze_o=1 all slots hold. When LOAD_LAT=1, no registered slots exist.
- Hazard (combinational): any valid slot whose rd equals ifid_rs1_i with ifid_use_rs1_i=1, or equals ifid_rs2_i with ifid_use_rs2_i=1. Register 0 never hazards.
- Output priority, highest first:
  1. dmem_busy_i=1: freeze_o=1, stall_o=1, pcwrite_o=0, noop_o=0, flush_o=0. A branch flush is deferred; branch_taken_i is held by the frozen pipe.
  2. branch_taken_i=1: flush_o=1, pcwrite_o=1, noop_o=0, stall_o=0. The ID instruction is squashed, so the hazard is ignored.
  3. hazard=1: noop_o=1, stall_o=1, pcwrite_o=0.
  4. Otherwise idle: noop_o=0, stall_o=0, flush_o=0, freeze_o=0, pcwrite_o=1.
- Latency: a dependent instruction directly behind a load stalls exactly LOAD_LAT cycles. An independent instruction between them reduces this by 1 per intervening instruction, down to 0.
- Counter: increments by 1 on each cycle the case-3 outputs are driven, saturates at all ones, and does not count during freeze. clr_cnt_i zeroes it next cycle and wins over a simultaneous increment.
- Reset (rst_i=1 at clock edge): all slots invalid, stall_cnt_o=0. While rst_i=1, outputs are forced to idle values regardless of inputs.
- Reset asserted mid-stall: the stall drops in the same cycle and the tracker is empty on the next cycle.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_ADDR_W default;
  - load_slot_t typedef {valid, rd};
  - ZERO_REG constant.
- One sub-module, load_track_pipe, contains the parametrised slot shift register with hold and synchronous clear. It exposes slot vectors; the comparison and priority logic stay in the top.

Test Plan:
- LOAD_LAT=1; load x5 in ID/EX, add x6,x5,x1 in IF/ID (use both) -> noop_o=1, stall_o=1, pcwrite_o=0 for 1 cycle, then idle; stall_cnt_o=1.
- LOAD_LAT=3; same pair -> 3 consecutive stall cycles; with one independent instruction between them -> 2 cycles; stall_cnt_o=3 then 5.
- Load x0, or rs2 matching with ifid_use_rs2_i=0 -> no stall; outputs idle.
- LOAD_LAT=2, hazard active, dmem_busy_i=1 for 2 cycles -> freeze_o=1, noop_o=0, counter holds; then hazard resumes for its remaining 1 cycle.
- branch_taken_i=1 coincident with a hazard -> flush_o=1, noop_o=0, pcwrite_o=1; branch_taken_i with dmem_busy_i=1 -> flush_o=0 until busy drops.
- Counter at 16'hFFFE with 3 stall cycles -> stays 16'hFFFF; rst_i asserted mid-stall -> next cycle outputs idle, counter 0.
